mor1kx_rf_mp_marocchino: RTL
============================

Name: mor1kx_rf_mp_marocchino

Overview:
Parametrised multi-port GPR file for the MAROCCHINO pipeline. It is the successor to the single-writeback RF and supports NUM_RD_PORTS registered read ports and NUM_WR_PORTS writeback ports. Read outputs are held and kept coherent with later writebacks. A per-register busy scoreboard tracks in-flight destinations, and SPR-bus GPR access uses a small read FSM. It sits between FETCH (read addresses), the issue logic, and the writeback stages.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width (DW)
OPTION_RF_ADDR_WIDTH, 5, GPR address width (AW); 2^AW registers
NUM_RD_PORTS, 2, read ports (1..4)
NUM_WR_PORTS, 2, writeback ports (1..4)
FEATURE_R0_ZERO, 1, when 1: r0 always reads 0 and writes to r0 are ignored

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
pipeline_flush_i  in  1  flush: clears scoreboard and suppresses writes this cycle
rd_adr_valid_i  in  1  latch new read addresses
rd_adr_i  in  NUM_RD_PORTS*AW  read addresses, port k at [k*AW +: AW]
rd_dat_o  out  NUM_RD_PORTS*DW  registered read data
rd_busy_o  out  NUM_RD_PORTS  combinational scoreboard bit of rd_adr_i[k]
issue_i  in  1  instruction with destination issued
issue_rfd_adr_i  in  AW  destination of issued instruction
wr_en_i  in  NUM_WR_PORTS  writeback strobes (1-clock)
wr_adr_i  in  NUM_WR_PORTS*AW  writeback addresses
wr_dat_i  in  NUM_WR_PORTS*DW  writeback data
spr_bus_addr_i  in  16  SPR address
spr_bus_stb_i  in  1  SPR strobe
spr_bus_we_i  in  1  SPR write
spr_bus_dat_i  in  DW  SPR write data
spr_gpr_ack_o  out  1  SPR GPR access acknowledge
spr_gpr_dat_o  out  DW  SPR GPR read data

Behaviour:
- Reset (rst_n=0, async): register array, rd_dat_o, held read addresses, busy bits and spr_gpr_dat_o all go to 0; SPR FSM goes to IDLE; spr_gpr_ack_o=0.
- Effective write k: wr_en_i[k] & ~pipeline_flush_i & ~(FEATURE_R0_ZERO & adr==0). The array updates at the clock edge.
- Same-address write collision: the highest-index port wins.
- Read, 1-cycle latency: on rd_adr_valid_i the held address is set to rd_adr_i[k]. rd_dat_o[k] next cycle = data of the winning effective write to that address in the same cycle, else the array content (pre-write).
- Hold coherence: while rd_adr_valid_i=0, any effective write to held address k updates rd_dat_o[k] at the next edge (winning port). rd_dat_o therefore always equals the current architectural value of the held register.
- r0 with FEATURE_R0_ZERO=1: rd_dat_o is 0.
- Scoreboard busy[2^AW]:
  - issue_i sets busy[issue_rfd_adr_i] (never for r0 when FEATURE_R0_ZERO).
  - An effective write clears busy[wr_adr].
  - Issue and write to the same address in the same cycle: busy stays 1.
  - pipeline_flush_i clears all bits and overrides issue.
- SPR select: spr_bus_addr_i[15:9]==7'h2; register index is spr_bus_addr_i[AW-1:0].
- SPR write:
  - ack is combinational: spr_gpr_ack_o = sel & stb & we & ~(|wr_en_i).
  - The array is written at the edge when ack=1.
  - While any wr_en_i is high, ack stays 0 (stall); the requester holds stb.
- SPR read FSM:
  - IDLE -> RD when sel&stb&~we.
  - RD: latch array[index] into spr_gpr_dat_o, go to ACK.
  - ACK: spr_gpr_ack_o=1 for exactly one cycle, then IDLE.
  - stb deasserted in RD aborts to IDLE with no ack.
  - A writeback to the same index in the RD cycle is forwarded into spr_gpr_dat_o.
  - Read latency is 2 cycles from strobe to ack.
- Flush mid-SPR access does not affect the SPR FSM.

Test Plan:
- Write r5=0x1234 on port 0, next cycle read r5 on port 1 -> rd_dat_o[1]=0x1234 one cycle after rd_adr_valid_i.
- Same-cycle write r7=0xA (port 0) and r7=0xB (port 1) with rd_adr_valid_i on r7 -> rd_dat_o=0xB; array r7=0xB.
- Latch r3, hold rd_adr_valid_i=0, write r3=0xDEAD two cycles later -> rd_dat_o updates to 0xDEAD next cycle; a write to r4 leaves it unchanged.
- issue_i r9 -> rd_busy_o=1 for r9; issue r9 plus write r9 in the same cycle -> stays 1; flush -> 0; write r0=0x55 -> r0 reads 0, busy[0] never set.
- SPR read addr 0x0406 while port 1 writes r6=0x77 in the RD cycle -> ack in cycle 2 with spr_gpr_dat_o=0x77.
- SPR write addr 0x0408 with wr_en_i=1 for 2 cycles -> ack low for 2 cycles, then high; r8=spr_bus_dat_i. Assert rst_n low mid-SPR-read -> ack=0, FSM IDLE immediately.

Source files
------------

// File: rtl/mor1kx_rf_mp_marocchino.sv
// Multi-port GPR file for the MAROCCHINO pipeline: registered, write-coherent read ports,
// N writeback ports, per-register busy scoreboard and an SPR-bus GPR access path.
module mor1kx_rf_mp_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS         = 2,
  parameter int NUM_WR_PORTS         = 2,
  parameter int FEATURE_R0_ZERO      = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         pipeline_flush_i,
  input  logic                                         rd_adr_valid_i,
  input  logic [NUM_RD_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
  output logic [NUM_RD_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_dat_o,
  output logic [NUM_RD_PORTS-1:0]                      rd_busy_o,
  input  logic                                         issue_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]              issue_rfd_adr_i,
  input  logic [NUM_WR_PORTS-1:0]                      wr_en_i,
  input  logic [NUM_WR_PORTS*OPTION_RF_ADDR_WIDTH-1:0] wr_adr_i,
  input  logic [NUM_WR_PORTS*OPTION_OPERAND_WIDTH-1:0] wr_dat_i,
  input  logic [15:0]                                  spr_bus_addr_i,
  input  logic                                         spr_bus_stb_i,
  input  logic                                         spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]              spr_bus_dat_i,
  output logic                                         spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]              spr_gpr_dat_o,
  output logic [1:0]                                   spr_fsm_state_o
);

  localparam int DW    = OPTION_OPERAND_WIDTH;
  localparam int AW    = OPTION_RF_ADDR_WIDTH;
  localparam int NREGS = 1 << AW;
  localparam bit R0Z   = (FEATURE_R0_ZERO != 0);

  localparam logic [1:0] SPR_IDLE = 2'd0;
  localparam logic [1:0] SPR_RD   = 2'd1;
  localparam logic [1:0] SPR_ACK  = 2'd2;

  logic [DW-1:0]                       r_mem [NREGS];
  logic [NUM_RD_PORTS-1:0][AW-1:0]     r_rd_adr;
  logic [NUM_RD_PORTS-1:0][DW-1:0]     r_rd_dat;
  logic [NREGS-1:0]                    r_busy;
  logic [1:0]                          r_spr_state;
  logic [DW-1:0]                       r_spr_dat;

  logic [NUM_WR_PORTS-1:0]             w_wr_eff;
  logic [NUM_RD_PORTS-1:0][AW-1:0]     w_rd_adr_nxt;
  logic [NUM_RD_PORTS-1:0][DW-1:0]     w_rd_dat_nxt;
  logic [NREGS-1:0]                    w_busy_nxt;
  logic                                w_spr_sel;
  logic [AW-1:0]                       w_spr_idx;
  logic                                w_spr_wr_ack;
  logic                                w_spr_wr_eff;
  logic [DW-1:0]                       w_spr_rd_dat;
  logic                                w_unused_spr_addr;

  assign w_spr_sel         = (spr_bus_addr_i[15:9] == 7'h2);
  assign w_spr_idx         = spr_bus_addr_i[AW-1:0];
  assign w_unused_spr_addr = ^spr_bus_addr_i[8:AW];
  assign w_spr_wr_ack      = w_spr_sel & spr_bus_stb_i & spr_bus_we_i & ~(|wr_en_i);
  assign w_spr_wr_eff      = w_spr_wr_ack & ~(R0Z & (w_spr_idx == '0));

  assign rd_dat_o        = r_rd_dat;
  assign spr_gpr_dat_o   = r_spr_dat;
  assign spr_fsm_state_o = r_spr_state;
  assign spr_gpr_ack_o   = w_spr_wr_ack | (r_spr_state == SPR_ACK);

  always_comb begin
    for (int j = 0; j < NUM_WR_PORTS; j++)
      w_wr_eff[j] = wr_en_i[j] & ~pipeline_flush_i & ~(R0Z & (wr_adr_i[j*AW +: AW] == '0));
  end

  // Next read data: ascending port loop lets the highest-index write win.
  always_comb begin
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      w_rd_adr_nxt[k] = rd_adr_valid_i ? rd_adr_i[k*AW +: AW] : r_rd_adr[k];
      w_rd_dat_nxt[k] = r_mem[w_rd_adr_nxt[k]];
      for (int j = 0; j < NUM_WR_PORTS; j++)
        if (w_wr_eff[j] && (wr_adr_i[j*AW +: AW] == w_rd_adr_nxt[k]))
          w_rd_dat_nxt[k] = wr_dat_i[j*DW +: DW];
      if (w_spr_wr_eff && (w_spr_idx == w_rd_adr_nxt[k]))
        w_rd_dat_nxt[k] = spr_bus_dat_i;
      if (R0Z && (w_rd_adr_nxt[k] == '0))
        w_rd_dat_nxt[k] = '0;
    end
  end

  always_comb begin
    w_spr_rd_dat = r_mem[w_spr_idx];
    for (int j = 0; j < NUM_WR_PORTS; j++)
      if (w_wr_eff[j] && (wr_adr_i[j*AW +: AW] == w_spr_idx))
        w_spr_rd_dat = wr_dat_i[j*DW +: DW];
  end

  // Issue is applied after the clears so a same-cycle issue keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR_PORTS; j++)
      if (w_wr_eff[j]) w_busy_nxt[wr_adr_i[j*AW +: AW]] = 1'b0;
    if (issue_i && !(R0Z && (issue_rfd_adr_i == '0)))
      w_busy_nxt[issue_rfd_adr_i] = 1'b1;
    if (pipeline_flush_i)
      w_busy_nxt = '0;
  end

  always_comb begin
    for (int k = 0; k < NUM_RD_PORTS; k++)
      rd_busy_o[k] = r_busy[rd_adr_i[k*AW +: AW]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR_PORTS; j++)
        if (w_wr_eff[j]) r_mem[wr_adr_i[j*AW +: AW]] <= wr_dat_i[j*DW +: DW];
      if (w_spr_wr_eff) r_mem[w_spr_idx] <= spr_bus_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_adr <= '0;
      r_rd_dat <= '0;
      r_busy   <= '0;
    end else begin
      r_rd_adr <= w_rd_adr_nxt;
      r_rd_dat <= w_rd_dat_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spr_state <= SPR_IDLE;
      r_spr_dat   <= '0;
    end else begin
      case (r_spr_state)
        SPR_IDLE: if (w_spr_sel && spr_bus_stb_i && !spr_bus_we_i) r_spr_state <= SPR_RD;
        SPR_RD: begin
          if (!spr_bus_stb_i) begin
            r_spr_state <= SPR_IDLE;
          end else begin
            r_spr_dat   <= w_spr_rd_dat;
            r_spr_state <= SPR_ACK;
          end
        end
        default: r_spr_state <= SPR_IDLE;
      endcase
    end
  end

endmodule
